// File: rtl/vec_csr_ctrl_pkg.sv
// Shared definitions for the vector configuration sequencer: request types,
// controller states and vtype field positions.
package vec_csr_ctrl_pkg;

  typedef enum logic [1:0] {
    CFG_VSETVLI  = 2'b00,
    CFG_VSETIVLI = 2'b01,
    CFG_VSETVL   = 2'b10,
    CFG_RSVD     = 2'b11
  } cfg_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    WB   = 2'b10
  } csr_ctrl_state_e;

  localparam int VTYPE_VLMUL_LSB = 0;
  localparam int VTYPE_VLMUL_MSB = 2;
  localparam int VTYPE_VSEW_LSB  = 3;
  localparam int VTYPE_VSEW_MSB  = 5;
  localparam int VTYPE_VTA       = 6;
  localparam int VTYPE_VMA       = 7;
  localparam int VTYPE_RSVD_LSB  = 8;

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational VLMAX and SEW/LMUL legality for one vtype encoding.
module vec_vlmax_calc #(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int ELEN = 64
) (
  input  logic [2:0]      vsew,
  input  logic [2:0]      vlmul,
  output logic [XLEN-1:0] vlmax,
  output logic            legal
);

  logic [XLEN-1:0] w_base;
  logic [31:0]     w_frac_bits;

  // Fractional LMUL 1/n is only legal when SEW*n fits inside ELEN.
  always_comb begin
    w_base      = XLEN'(VLEN >> (32'd3 + {29'd0, vsew}));
    w_frac_bits = 32'd8 << ({30'd0, vsew[1:0]} + (32'd8 - {29'd0, vlmul}));
    vlmax       = '0;
    legal       = 1'b1;
    if (!vlmul[2]) begin
      vlmax = w_base << vlmul;
    end else begin
      vlmax = w_base >> (4'd8 - {1'b0, vlmul});
    end
    if (vsew[2]) begin
      legal = 1'b0;
    end
    if (vlmul == 3'b100) begin
      legal = 1'b0;
    end
    if (vlmul[2] && (vlmul != 3'b100) && (w_frac_bits > 32'(ELEN))) begin
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/vec_csr_ctrl.sv
// Sequencer for VSETVLI/VSETIVLI/VSETVL: captures a request, updates vl/vtype
// and returns the new vl to the scalar register file.
module vec_csr_ctrl
  import vec_csr_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int ELEN = 64
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [1:0]      cfg_type,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      uimm,
  input  logic [10:0]     zimm,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] csr_vl,
  output logic [XLEN-1:0] csr_vtype,
  output logic            vill,
  output logic            busy
);

  localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

  csr_ctrl_state_e r_state;
  cfg_type_e       r_cfg_type;
  logic [4:0]      r_rs1_addr;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [4:0]      r_uimm;
  logic [10:0]     r_zimm;
  logic [XLEN-1:0] r_csr_vl;
  logic [XLEN-1:0] r_csr_vtype;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  logic [XLEN-1:0] w_vtype;
  logic [XLEN-1:0] w_avl;
  logic [XLEN-1:0] w_vlmax;
  logic [XLEN-1:0] w_new_vl;
  logic            w_calc_legal;
  logic            w_legal;

  vec_vlmax_calc #(
    .XLEN(XLEN),
    .VLEN(VLEN),
    .ELEN(ELEN)
  ) u_vlmax (
    .vsew (w_vtype[VTYPE_VSEW_MSB:VTYPE_VSEW_LSB]),
    .vlmul(w_vtype[VTYPE_VLMUL_MSB:VTYPE_VLMUL_LSB]),
    .vlmax(w_vlmax),
    .legal(w_calc_legal)
  );

  // rs1=x0 with rd=x0 keeps the current vl, clamped to the new VLMAX.
  always_comb begin
    w_vtype = '0;
    w_avl   = '0;
    case (r_cfg_type)
      CFG_VSETVLI:  w_vtype = XLEN'(r_zimm);
      CFG_VSETIVLI: w_vtype = XLEN'(r_zimm[9:0]);
      default:      w_vtype = r_rs2_data;
    endcase
    if (r_cfg_type == CFG_VSETIVLI) begin
      w_avl = XLEN'(r_uimm);
    end else if (r_rs1_addr != 5'd0) begin
      w_avl = r_rs1_data;
    end else if (r_rd_addr != 5'd0) begin
      w_avl = '1;
    end else begin
      w_avl = r_csr_vl;
    end
    w_legal  = w_calc_legal && (w_vtype[XLEN-1:VTYPE_RSVD_LSB] == '0) &&
               (r_cfg_type != CFG_RSVD);
    w_new_vl = (w_avl < w_vlmax) ? w_avl : w_vlmax;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_cfg_type  <= CFG_VSETVLI;
      r_rs1_addr  <= '0;
      r_rd_addr   <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_uimm      <= '0;
      r_zimm      <= '0;
      r_csr_vl    <= '0;
      r_csr_vtype <= VILL_VTYPE;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inst_valid) begin
            r_cfg_type <= cfg_type_e'(cfg_type);
            r_rs1_addr <= rs1_addr;
            r_rd_addr  <= rd_addr;
            r_rs1_data <= rs1_data;
            r_rs2_data <= rs2_data;
            r_uimm     <= uimm;
            r_zimm     <= zimm;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_csr_vtype <= w_legal ? w_vtype : VILL_VTYPE;
          r_csr_vl    <= w_legal ? w_new_vl : '0;
          r_wb_data   <= w_legal ? w_new_vl : '0;
          r_wb_rd     <= r_rd_addr;
          r_state     <= (r_rd_addr == 5'd0) ? IDLE : WB;
        end
        WB: begin
          if (wb_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inst_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign wb_valid   = (r_state == WB);
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign csr_vl     = r_csr_vl;
  assign csr_vtype  = r_csr_vtype;
  assign vill       = r_csr_vtype[XLEN-1];

endmodule

// File: tb/tb_vec_csr_ctrl.sv
// Directed self-checking bench for vec_csr_ctrl: configuration requests with
// hand-computed vl/vtype results, backpressure and asynchronous reset.
module tb_vec_csr_ctrl;

  logic        clk;
  logic        n_rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  cfg_type;
  logic [4:0]  rs1_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  uimm;
  logic [10:0] zimm;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] csr_vl;
  logic [31:0] csr_vtype;
  logic        vill;
  logic        busy;

  int total;
  int bad;

  vec_csr_ctrl #(
    .XLEN(32),
    .VLEN(512),
    .ELEN(64)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .cfg_type  (cfg_type),
    .rs1_addr  (rs1_addr),
    .rd_addr   (rd_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .uimm      (uimm),
    .zimm      (zimm),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .csr_vl    (csr_vl),
    .csr_vtype (csr_vtype),
    .vill      (vill),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; returns #1 after the CALC edge.
  task automatic applyStimulus(input logic [1:0] t, input logic [4:0] rs1a, input logic [4:0] rda,
                               input logic [31:0] rs1d, input logic [31:0] rs2d,
                               input logic [4:0] ui, input logic [10:0] zi);
    cfg_type   = t;
    rs1_addr   = rs1a;
    rd_addr    = rda;
    rs1_data   = rs1d;
    rs2_data   = rs2d;
    uimm       = ui;
    zimm       = zi;
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    checkOutput("calc_busy", {31'd0, busy}, 32'd1);
    checkOutput("calc_ready", {31'd0, inst_ready}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic releaseWb();
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    checkOutput("wb_drop", {31'd0, wb_valid}, 32'd0);
    checkOutput("idle_ready", {31'd0, inst_ready}, 32'd1);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    n_rst      = 1'b0;
    inst_valid = 1'b0;
    wb_ready   = 1'b0;
    cfg_type   = 2'b00;
    rs1_addr   = '0;
    rd_addr    = '0;
    rs1_data   = '0;
    rs2_data   = '0;
    uimm       = '0;
    zimm       = '0;

    #12;
    checkOutput("rst_vl", csr_vl, 32'h0);
    checkOutput("rst_vtype", csr_vtype, 32'h8000_0000);
    checkOutput("rst_vill", {31'd0, vill}, 32'd1);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ready", {31'd0, inst_ready}, 32'd1);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // VSETVLI e8,m1: VLMAX=64, AVL=100
    applyStimulus(2'b00, 5'd5, 5'd1, 32'd100, 32'h0, 5'd0, 11'h000);
    checkOutput("vsetvli_vl", csr_vl, 32'd64);
    checkOutput("vsetvli_vtype", csr_vtype, 32'h0);
    checkOutput("vsetvli_vill", {31'd0, vill}, 32'd0);
    checkOutput("vsetvli_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("vsetvli_wb_rd", {27'd0, wb_rd}, 32'd1);
    checkOutput("vsetvli_wb_data", wb_data, 32'd64);
    releaseWb();

    // VSETIVLI uimm=5, e64,m1: VLMAX=8
    applyStimulus(2'b01, 5'd0, 5'd2, 32'hdead_beef, 32'h0, 5'd5, 11'h018);
    checkOutput("vsetivli_vl", csr_vl, 32'd5);
    checkOutput("vsetivli_vtype", csr_vtype, 32'h18);
    checkOutput("vsetivli_wb_data", wb_data, 32'd5);
    checkOutput("vsetivli_wb_rd", {27'd0, wb_rd}, 32'd2);
    releaseWb();

    // VSETVL rs1=x0 rd=x3, e32,m8: VLMAX=128
    applyStimulus(2'b10, 5'd0, 5'd3, 32'd7, 32'h13, 5'd0, 11'h0);
    checkOutput("vsetvl_vl", csr_vl, 32'd128);
    checkOutput("vsetvl_vtype", csr_vtype, 32'h13);
    checkOutput("vsetvl_wb_rd", {27'd0, wb_rd}, 32'd3);
    checkOutput("vsetvl_wb_data", wb_data, 32'd128);
    releaseWb();

    // Reserved LMUL
    applyStimulus(2'b10, 5'd5, 5'd4, 32'd10, 32'h1C, 5'd0, 11'h0);
    checkOutput("ill_lmul_vill", {31'd0, vill}, 32'd1);
    checkOutput("ill_lmul_vtype", csr_vtype, 32'h8000_0000);
    checkOutput("ill_lmul_vl", csr_vl, 32'd0);
    checkOutput("ill_lmul_wb_data", wb_data, 32'd0);
    releaseWb();

    // Restore a legal config so the next illegal result is observable
    applyStimulus(2'b00, 5'd5, 5'd1, 32'd20, 32'h0, 5'd0, 11'h000);
    checkOutput("relegal_vl", csr_vl, 32'd20);
    releaseWb();

    // e64,mf2: SEW*2=128 > ELEN
    applyStimulus(2'b10, 5'd5, 5'd4, 32'd10, 32'h1F, 5'd0, 11'h0);
    checkOutput("ill_frac_vill", {31'd0, vill}, 32'd1);
    checkOutput("ill_frac_vtype", csr_vtype, 32'h8000_0000);
    checkOutput("ill_frac_vl", csr_vl, 32'd0);
    checkOutput("ill_frac_wb_data", wb_data, 32'd0);
    releaseWb();

    // Reserved cfg_type with an otherwise legal vtype
    applyStimulus(2'b11, 5'd5, 5'd8, 32'd10, 32'h0, 5'd0, 11'h0);
    checkOutput("rsvd_type_vill", {31'd0, vill}, 32'd1);
    checkOutput("rsvd_type_vl", csr_vl, 32'd0);
    releaseWb();

    // e8,mf4 is legal: VLMAX=64>>2=16
    applyStimulus(2'b00, 5'd5, 5'd9, 32'd100, 32'h0, 5'd0, 11'h006);
    checkOutput("frac_vl", csr_vl, 32'd16);
    checkOutput("frac_vtype", csr_vtype, 32'h6);
    releaseWb();

    // Backpressure: hold wb_ready low while a new request is offered
    applyStimulus(2'b00, 5'd5, 5'd6, 32'd100, 32'h0, 5'd0, 11'h000);
    cfg_type   = 2'b01;
    rd_addr    = 5'd7;
    uimm       = 5'd3;
    zimm       = 11'h018;
    inst_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
      checkOutput("bp_wb_rd", {27'd0, wb_rd}, 32'd6);
      checkOutput("bp_wb_data", wb_data, 32'd64);
      checkOutput("bp_ready", {31'd0, inst_ready}, 32'd0);
      checkOutput("bp_vl", csr_vl, 32'd64);
    end
    inst_valid = 1'b0;
    releaseWb();

    // Keep-vl: rs1=x0 rd=x0, e16,m1 (VLMAX=32), current vl=64
    wb_ready = 1'b1;
    applyStimulus(2'b00, 5'd0, 5'd0, 32'd0, 32'h0, 5'd0, 11'h008);
    wb_ready = 1'b0;
    checkOutput("keep_vl", csr_vl, 32'd32);
    checkOutput("keep_vtype", csr_vtype, 32'h8);
    checkOutput("keep_no_wb", {31'd0, wb_valid}, 32'd0);
    checkOutput("keep_busy", {31'd0, busy}, 32'd0);
    checkOutput("keep_ready", {31'd0, inst_ready}, 32'd1);

    // Asynchronous reset in the middle of WB
    applyStimulus(2'b00, 5'd5, 5'd5, 32'd9, 32'h0, 5'd0, 11'h000);
    checkOutput("pre_rst_wb_valid", {31'd0, wb_valid}, 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("arst_vl", csr_vl, 32'd0);
    checkOutput("arst_vtype", csr_vtype, 32'h8000_0000);
    checkOutput("arst_vill", {31'd0, vill}, 32'd1);
    checkOutput("arst_ready", {31'd0, inst_ready}, 32'd1);
    #2;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
